// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft: write side, first-word-fall-through read side and status.
// The master drives requests; the FIFO (slave) drives data and status.
interface sync_fifo_fwft_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  wrEn;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  full;
  logic                  rdEn;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;
  logic [ADDR_WIDTH:0]   count;
  logic                  wrErr;

  modport master (
    output wrEn, wrData, rdEn,
    input  full, rdData, rdValid, count, wrErr
  );

  modport slave (
    input  wrEn, wrData, rdEn,
    output full, rdData, rdValid, count, wrErr
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO on a simple dual-port RAM.
// The RAM read register is the output: the head word is prefetched so it is visible without a read strobe.

module SyncRAMSimpleDualPort #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  enA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dA,
  input  logic                  enB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  output logic [DATA_WIDTH-1:0] qB
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] qb_q;

  // NOTE: storage and read register are deliberately not reset, so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (enA) mem[addrA] <= dA;
    if (enB) qb_q <= mem[addrB];
  end

  assign qB = qb_q;
endmodule

module sync_fifo_fwft #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_fifo_fwft_if.slave     fifo
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] ptr_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic rd_valid_q, rd_valid_d;
  logic wr_err_q, wr_err_d;
  logic push, pop, fetch;
  logic [DATA_WIDTH-1:0] ram_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    push       = fifo.wrEn && !full_q;
    pop        = fifo.rdEn && rd_valid_q;
    wr_ptr_d   = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    // Fetch against the pre-edge write pointer: a word written this edge is not yet readable.
    fetch      = (!rd_valid_q || pop) && (rd_ptr_d != wr_ptr_q);
    rd_valid_d = rd_valid_q;
    if (fetch)    rd_valid_d = 1'b1;
    else if (pop) rd_valid_d = 1'b0;
    count_d    = wr_ptr_d - rd_ptr_d;
    full_d     = (count_d == ptr_t'(DEPTH));
    wr_err_d   = wr_err_q || (fifo.wrEn && full_q);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking is reserved for always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  SyncRAMSimpleDualPort #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .enA  (push),
    .addrA(wr_ptr_q[ADDR_WIDTH-1:0]),
    .dA   (fifo.wrData),
    .enB  (fetch),
    .addrB(rd_ptr_d[ADDR_WIDTH-1:0]),
    .qB   (ram_q)
  );

  assign fifo.rdData  = ram_q;
  assign fifo.rdValid = rd_valid_q;
  assign fifo.count   = count_q;
  assign fifo.full    = full_q;
  assign fifo.wrErr   = wr_err_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: directed scenarios then random traffic,
// all compared against a queue model of FIFO occupancy and head visibility.
module tb_sync_fifo_fwft;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f ();

  sync_fifo_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fifo (f.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: queue of accepted words; head visible one edge after it was resident pre-edge.
  logic [DW-1:0] mq[$];
  bit m_valid = 0;
  bit m_err   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},   64'(f.count),   64'(mq.size()));
    check({tag, ".full"},    64'(f.full),    64'(mq.size() == DEPTH));
    check({tag, ".rdValid"}, 64'(f.rdValid), 64'(m_valid));
    check({tag, ".wrErr"},   64'(f.wrErr),   64'(m_err));
    if (m_valid) check({tag, ".rdData"}, 64'(f.rdData), 64'(mq[0]));
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 0;
    m_err   = 0;
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input string tag, input bit wr, input logic [DW-1:0] d, input bit rd);
    int s;
    bit w, p;
    @(negedge clk);
    f.wrEn   = wr;
    f.wrData = d;
    f.rdEn   = rd;
    s = mq.size();
    w = wr && (s < DEPTH);
    p = rd && m_valid;
    if (wr && s == DEPTH) m_err = 1;
    @(posedge clk);
    #1;
    if (p) void'(mq.pop_front());
    if (w) mq.push_back(d);
    m_valid = (s - int'(p)) > 0;
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    f.wrEn   = 1'b0;
    f.wrData = '0;
    f.rdEn   = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push into empty FIFO, then held with rdEn low.
    cycle("push_a5", 1, 32'hA5A5_A5A5, 0);
    for (int i = 0; i < 6; i++) cycle("hold_a5", 0, '0, 0);
    check("a5_data", 64'(f.rdData), 64'hA5A5_A5A5);
    cycle("drain_a5", 0, '0, 1);
    cycle("empty_a5", 0, '0, 0);

    // Fill to full, overflow write, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, DW'(i), 0);
    check("fill_full",  64'(f.full),  64'd1);
    check("fill_count", 64'(f.count), 64'd16);
    cycle("overflow", 1, 32'd99, 0);
    check("overflow_err", 64'(f.wrErr), 64'd1);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 0, '0, 1);
    check("drain_count", 64'(f.count),   64'd0);
    check("drain_valid", 64'(f.rdValid), 64'd0);
    check("drain_err",   64'(f.wrErr),   64'd1);

    // Steady push+pop from two resident words across pointer wrap.
    cycle("stream_pre", 1, 32'h100, 0);
    cycle("stream_pre", 1, 32'h101, 0);
    for (int i = 0; i < 40; i++) begin
      cycle("stream", 1, DW'(32'h102 + i), 1);
      check("stream_gap",   64'(f.rdValid), 64'd1);
      check("stream_count", 64'(f.count),   64'd2);
    end
    cycle("stream_drain", 0, '0, 1);
    cycle("stream_drain", 0, '0, 1);
    cycle("stream_empty", 0, '0, 0);

    // One resident word: pop and push 0x55 together opens a one-cycle bubble.
    cycle("bubble_pre", 1, 32'h33, 0);
    cycle("bubble_pre", 0, '0, 0);
    cycle("bubble", 1, 32'h55, 1);
    check("bubble_gap", 64'(f.rdValid), 64'd0);
    cycle("bubble_post", 0, '0, 0);
    check("bubble_data",  64'(f.rdData), 64'h55);
    check("bubble_count", 64'(f.count),  64'd1);
    cycle("bubble_drain", 0, '0, 1);

    // Read requests while empty are ignored.
    for (int i = 0; i < 5; i++) cycle("empty_rd", 0, '0, 1);
    check("empty_rd_count", 64'(f.count), 64'd0);
    cycle("empty_rd_push", 1, 32'h77, 0);
    cycle("empty_rd_head", 0, '0, 0);
    check("empty_rd_data", 64'(f.rdData), 64'h77);
    cycle("empty_rd_drain", 0, '0, 1);

    // Asynchronous reset between edges with seven words resident.
    for (int i = 0; i < 7; i++) cycle("pre_rst", 1, DW'(32'h200 + i), 0);
    f.wrEn = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_count", 64'(f.count),   64'd0);
    check("async_valid", 64'(f.rdValid), 64'd0);
    check("async_err",   64'(f.wrErr),   64'd0);
    check("async_full",  64'(f.full),    64'd0);
    #1;
    rst_n = 1'b1;
    cycle("post_rst_push", 1, 32'h1, 0);
    cycle("post_rst_head", 0, '0, 0);
    check("post_rst_data", 64'(f.rdData), 64'h1);

    // Random traffic; write bias alternates so both full and empty are visited.
    for (int i = 0; i < 600; i++) begin
      bit wr, rd;
      if ((i / 100) % 2 == 0) begin
        wr = ($urandom_range(0, 9) < 8);
        rd = ($urandom_range(0, 9) < 3);
      end else begin
        wr = ($urandom_range(0, 9) < 3);
        rd = ($urandom_range(0, 9) < 8);
      end
      cycle("random", wr, DW'($urandom), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
